// File: rtl/contador_param.sv
// Parametrised up/down counter with programmable modulus, wrap/saturate mode,
// clock-enable prescaler, synchronous parallel load and step/terminal strobes.
module contador_param #(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 255,
  parameter int          SATURATE = 0,
  parameter int          PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             sat
);

  localparam int              PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX       = WIDTH'(MAX_VAL);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam bit              FULL_RANGE = (longint'(MAX_VAL) == ((longint'(1) << WIDTH) - 1));

  logic [PRE_W-1:0] pre;
  logic [WIDTH-1:0] step_count;
  logic [WIDTH-1:0] load_clamped;
  logic             step;
  logic             terminal;

  assign step     = en && (pre == PRE_LAST);
  assign terminal = up_dn ? (count == MAX) : (count == '0);
  assign sat      = (SATURATE != 0) && terminal;

  // When MAX_VAL spans the whole word no load value can exceed it.
  if (FULL_RANGE) begin : g_no_clamp
    assign load_clamped = load_val;
  end else begin : g_clamp
    assign load_clamped = (load_val > MAX) ? MAX : load_val;
  end

  // NOTE: step_count gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    step_count = count;
    if (up_dn) begin
      if (count == MAX) step_count = (SATURATE != 0) ? count : '0;
      else              step_count = count + 1'b1;
    end else begin
      if (count == '0)  step_count = (SATURATE != 0) ? count : MAX;
      else              step_count = count - 1'b1;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      pre   <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      pre   <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      tick <= step;
      tc   <= step && terminal;
      if (step) count <= step_count;
      if (en)   pre   <= step ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench: four differently configured counters share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_contador_param;

  logic       clk = 1'b0;
  logic       rst_n, en, up_dn, load;
  logic [7:0] lv8;
  logic [3:0] lv4;

  logic [7:0] cnt_a, cnt_d;
  logic [3:0] cnt_b, cnt_c;
  logic       tick_a, tick_b, tick_c, tick_d;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic       sat_a, sat_b, sat_c, sat_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // A: 8-bit full range wrap; B: mod-10 wrap; C: mod-10 saturate; D: max 150, prescale 4
  contador_param #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0), .PRESCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(lv8),
    .count(cnt_a), .tick(tick_a), .tc(tc_a), .sat(sat_a));
  contador_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4),
    .count(cnt_b), .tick(tick_b), .tc(tc_b), .sat(sat_b));
  contador_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4),
    .count(cnt_c), .tick(tick_c), .tc(tc_c), .sat(sat_c));
  contador_param #(.WIDTH(8), .MAX_VAL(150), .SATURATE(0), .PRESCALE(4)) dut_d (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(lv8),
    .count(cnt_d), .tick(tick_d), .tc(tc_d), .sat(sat_d));

  int cfg_max[4] = '{255, 9, 9, 150};
  int cfg_sat[4] = '{0, 0, 1, 0};
  int cfg_pre[4] = '{1, 1, 1, 4};

  int m_cnt[4], m_pre[4];
  bit m_tick[4], m_tc[4];
  bit model_valid = 1'b0;

  logic [31:0] d_cnt[4];
  logic        d_tick[4], d_tc[4], d_sat[4];
  assign d_cnt[0] = 32'(cnt_a);
  assign d_cnt[1] = 32'(cnt_b);
  assign d_cnt[2] = 32'(cnt_c);
  assign d_cnt[3] = 32'(cnt_d);
  assign d_tick = '{tick_a, tick_b, tick_c, tick_d};
  assign d_tc   = '{tc_a, tc_b, tc_c, tc_d};
  assign d_sat  = '{sat_a, sat_b, sat_c, sat_d};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: apply the counter rules at each edge using plain integers.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int lv;
      lv = (i == 1 || i == 2) ? int'(lv4) : int'(lv8);
      if (!rst_n) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_tick[i] = 0; m_tc[i] = 0;
      end else if (load) begin
        m_cnt[i] = (lv > cfg_max[i]) ? cfg_max[i] : lv;
        m_pre[i] = 0; m_tick[i] = 0; m_tc[i] = 0;
      end else if (en && m_pre[i] == cfg_pre[i] - 1) begin
        m_pre[i]  = 0;
        m_tick[i] = 1;
        if (up_dn) begin
          m_tc[i] = (m_cnt[i] == cfg_max[i]);
          if (m_tc[i]) m_cnt[i] = cfg_sat[i] ? m_cnt[i] : 0;
          else         m_cnt[i] = m_cnt[i] + 1;
        end else begin
          m_tc[i] = (m_cnt[i] == 0);
          if (m_tc[i]) m_cnt[i] = cfg_sat[i] ? m_cnt[i] : cfg_max[i];
          else         m_cnt[i] = m_cnt[i] - 1;
        end
      end else begin
        if (en) m_pre[i] = m_pre[i] + 1;
        m_tick[i] = 0; m_tc[i] = 0;
      end
    end
    if (!rst_n) model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 4; i++) begin
        bit exp_sat;
        exp_sat = (cfg_sat[i] != 0) && (up_dn ? (m_cnt[i] == cfg_max[i]) : (m_cnt[i] == 0));
        check($sformatf("count[%0d]", i), d_cnt[i], 32'(m_cnt[i]));
        check($sformatf("tick[%0d]", i), 32'(d_tick[i]), 32'(m_tick[i]));
        check($sformatf("tc[%0d]", i), 32'(d_tc[i]), 32'(m_tc[i]));
        check($sformatf("sat[%0d]", i), 32'(d_sat[i]), 32'(exp_sat));
      end
    end
  end

  // Drive one cycle's inputs just after the falling edge, return at the next one.
  task automatic cyc(input bit r, input bit e, input bit u, input bit l,
                     input logic [7:0] v8, input logic [3:0] v4);
    #1;
    rst_n = r; en = e; up_dn = u; load = l; lv8 = v8; lv4 = v4;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0; lv8 = '0; lv4 = '0;

    // Reset held two cycles with en high
    cyc(0, 1, 1, 0, 8'd0, 4'd0);
    cyc(0, 1, 1, 0, 8'd0, 4'd0);
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_tick", 32'(tick_a), 32'd0);
    check("rst_tc", 32'(tc_a), 32'd0);

    for (int k = 1; k <= 3; k++) begin
      cyc(1, 1, 1, 0, 8'd0, 4'd0);
      check("post_rst_count", 32'(cnt_a), 32'(k));
    end

    // Up wrap on the full-range counter; clamp on load for D
    cyc(1, 1, 1, 1, 8'd254, 4'd0);
    check("load_254", 32'(cnt_a), 32'd254);
    check("load_clamp", 32'(cnt_d), 32'd150);
    cyc(1, 1, 1, 0, 8'd0, 4'd0);
    check("up_255", 32'(cnt_a), 32'd255);
    check("up_255_tc", 32'(tc_a), 32'd0);
    cyc(1, 1, 1, 0, 8'd0, 4'd0);
    check("wrap_0", 32'(cnt_a), 32'd0);
    check("wrap_0_tc", 32'(tc_a), 32'd1);

    // Down wrap on mod-10
    cyc(1, 1, 0, 1, 8'd5, 4'd0);
    cyc(1, 1, 0, 0, 8'd0, 4'd0);
    check("dn_9", 32'(cnt_b), 32'd9);
    check("dn_9_tc", 32'(tc_b), 32'd1);
    cyc(1, 1, 0, 0, 8'd0, 4'd0);
    check("dn_8", 32'(cnt_b), 32'd8);
    check("dn_8_tc", 32'(tc_b), 32'd0);
    cyc(1, 1, 0, 0, 8'd0, 4'd0);
    check("dn_7", 32'(cnt_b), 32'd7);

    // Saturate at 9, then reverse
    cyc(1, 1, 1, 1, 8'd0, 4'd7);
    cyc(1, 1, 1, 0, 8'd0, 4'd0);
    cyc(1, 1, 1, 0, 8'd0, 4'd0);
    check("sat_9", 32'(cnt_c), 32'd9);
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 1, 0, 8'd0, 4'd0);
      check("sat_hold", 32'(cnt_c), 32'd9);
      check("sat_hold_tc", 32'(tc_c), 32'd1);
      check("sat_level", 32'(sat_c), 32'd1);
    end
    cyc(1, 1, 0, 0, 8'd0, 4'd0);
    check("sat_rev", 32'(cnt_c), 32'd8);
    check("sat_rev_lvl", 32'(sat_c), 32'd0);

    // Prescale by 4, then a period stretched by two disabled cycles
    cyc(1, 0, 1, 1, 8'd10, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 1, 1, 0, 8'd0, 4'd0);
      check("pre_count", 32'(cnt_d), (k == 4) ? 32'd11 : 32'd10);
      check("pre_tick", 32'(tick_d), (k == 4) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc(1, (k == 3 || k == 4) ? 1'b0 : 1'b1, 1, 0, 8'd0, 4'd0);
      check("stretch_count", 32'(cnt_d), (k == 6) ? 32'd12 : 32'd11);
      check("stretch_tick", 32'(tick_d), (k == 6) ? 32'd1 : 32'd0);
    end

    // Load beats a step and clears the prescaler phase
    cyc(1, 1, 1, 0, 8'd0, 4'd0);
    cyc(1, 1, 1, 0, 8'd0, 4'd0);
    cyc(1, 1, 1, 1, 8'd200, 4'd0);
    check("ld_win_a", 32'(cnt_a), 32'd200);
    check("ld_win_tick", 32'(tick_a), 32'd0);
    check("ld_win_d", 32'(cnt_d), 32'd150);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 1, 1, 0, 8'd0, 4'd0);
      check("ld_pre_count", 32'(cnt_d), (k == 4) ? 32'd0 : 32'd150);
      check("ld_pre_tc", 32'(tc_d), (k == 4) ? 32'd1 : 32'd0);
    end

    // Reset beats a simultaneous load
    cyc(0, 1, 1, 1, 8'd200, 4'd5);
    check("rst_vs_load", 32'(cnt_a), 32'd0);
    check("rst_vs_load_d", 32'(cnt_d), 32'd0);

    // Randomised run with sticky direction so boundaries are reached
    begin
      bit u;
      u = 1'b1;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(19) == 0) u = ~u;
        cyc(($urandom_range(99) != 0), ($urandom_range(3) != 0), u,
            ($urandom_range(15) == 0), 8'($urandom), 4'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
